// File: rtl/accelbrot_enter_deser.sv
// accelbrot_enter_deser: rebuilds word-serial enter beats into full blocks and queues them first-word-fall-through.
// Define ACCELBROT_ENTER_DESER_CHECK_EN to enable the saturating protocol/overflow error counter on sts_err.
module accelbrot_enter_deser #(
    parameter int NWORDS   = 8,
    parameter int WWIDTH   = 34,
    parameter int PWIDTH   = 12,
    parameter int DEPTH    = 4,
    parameter int BP_SLACK = 1,
    parameter int BWIDTH   = NWORDS * WWIDTH,
    parameter int TWIDTH   = PWIDTH * 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [WWIDTH-1:0] enter_a,
    input  logic [WWIDTH-1:0] enter_b,
    input  logic [TWIDTH-1:0] enter_tag,
    input  logic              enter_start,
    input  logic              enter_valid,
    output logic              enter_bp,
    output logic [BWIDTH-1:0] out_a,
    output logic [BWIDTH-1:0] out_b,
    output logic [TWIDTH-1:0] out_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       sts_num_queued,
    output logic [15:0]       sts_err
);

    localparam int CW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(NWORDS - 1);
    localparam logic [NW-1:0] FULL_CNT  = NW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ASSEMBLE = 2'd1;
    localparam logic [1:0] S_DROP     = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BWIDTH-1:0] asmA_q, asmA_d;
    logic [BWIDTH-1:0] asmB_q, asmB_d;
    logic [TWIDTH-1:0] tag_q, tag_d;

    logic [BWIDTH-1:0] memA [DEPTH];
    logic [BWIDTH-1:0] memB [DEPTH];
    logic [TWIDTH-1:0] memTag [DEPTH];
    logic [PW-1:0]     wrPtr_q, rdPtr_q;
    logic [NW-1:0]     count_q, count_d;
    logic              bp_q, bp_d;
    logic [31:0]       stsQueued_q;

    logic              commit;
    logic              pop;
    logic              slotFree;
    logic [BWIDTH-1:0] commitA, commitB;
    logic [TWIDTH-1:0] commitTag;
    logic [31:0]       usedNext;

    // A slot is reserved at the start beat; while assembling, the reservation guarantees count_q < DEPTH.
    assign slotFree = (count_q != FULL_CNT);
    assign pop      = out_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        asmA_d    = asmA_q;
        asmB_d    = asmB_q;
        tag_d     = tag_q;
        commit    = 1'b0;
        commitA   = asmA_q;
        commitB   = asmB_q;
        commitTag = tag_q;
        if (enter_valid) begin
            if (enter_start) begin
                if (!slotFree) begin
                    state_d = (NWORDS == 1) ? S_IDLE : S_DROP;
                    cnt_d   = CW'(1);
                end else if (NWORDS == 1) begin
                    commit    = 1'b1;
                    commitA   = BWIDTH'(enter_a);
                    commitB   = BWIDTH'(enter_b);
                    commitTag = enter_tag;
                    state_d   = S_IDLE;
                end else begin
                    state_d                = S_ASSEMBLE;
                    cnt_d                  = CW'(1);
                    asmA_d                 = '0;
                    asmB_d                 = '0;
                    asmA_d[WWIDTH-1:0]     = enter_a;
                    asmB_d[WWIDTH-1:0]     = enter_b;
                    tag_d                  = enter_tag;
                end
            end else if (state_q == S_ASSEMBLE) begin
                asmA_d[cnt_q*WWIDTH +: WWIDTH] = enter_a;
                asmB_d[cnt_q*WWIDTH +: WWIDTH] = enter_b;
                if (cnt_q == LAST_WORD) begin
                    commit  = 1'b1;
                    commitA = asmA_d;
                    commitB = asmB_d;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end else if (state_q == S_DROP) begin
                if (cnt_q == LAST_WORD) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    // Backpressure looks at next-cycle occupancy plus any reservation held by an assembly in progress.
    always_comb begin
        count_d  = count_q + NW'(commit) - NW'(pop);
        usedNext = 32'(count_d) + ((state_d == S_ASSEMBLE) ? 32'd1 : 32'd0);
        bp_d     = (usedNext + 32'(BP_SLACK)) >= 32'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            asmA_q      <= '0;
            asmB_q      <= '0;
            tag_q       <= '0;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            count_q     <= '0;
            bp_q        <= 1'b1;
            stsQueued_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            asmA_q      <= asmA_d;
            asmB_q      <= asmB_d;
            tag_q       <= tag_d;
            count_q     <= count_d;
            bp_q        <= bp_d;
            stsQueued_q <= 32'(count_q);
            if (commit) begin
                wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            memA[wrPtr_q]   <= commitA;
            memB[wrPtr_q]   <= commitB;
            memTag[wrPtr_q] <= commitTag;
        end
    end

    assign out_valid      = (count_q != '0);
    assign out_a          = out_valid ? memA[rdPtr_q] : '0;
    assign out_b          = out_valid ? memB[rdPtr_q] : '0;
    assign out_tag        = out_valid ? memTag[rdPtr_q] : '0;
    assign enter_bp       = bp_q;
    assign sts_num_queued = stsQueued_q;

`ifdef ACCELBROT_ENTER_DESER_CHECK_EN
    // At most one error per beat: orphan, mid-block restart, cut-short drop, or overflow.
    logic        errEvent;
    logic [15:0] err_q;

    assign errEvent = enter_valid &&
                      (enter_start ? ((state_q != S_IDLE) || !slotFree) : (state_q == S_IDLE));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= '0;
        end else if (errEvent && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign sts_err = err_q;
`else
    assign sts_err = 16'd0;
`endif

endmodule

// File: tb/tb_accelbrot_enter_deser.sv
// tb_accelbrot_enter_deser: segment table with hand-derived control expectations, then randomized traffic,
// every cycle compared against a queue-based block model.
module tb_accelbrot_enter_deser;

    localparam int NWORDS   = 8;
    localparam int WWIDTH   = 34;
    localparam int PWIDTH   = 12;
    localparam int DEPTH    = 4;
    localparam int BP_SLACK = 1;
    localparam int BWIDTH   = NWORDS * WWIDTH;
    localparam int TWIDTH   = PWIDTH * 2;

    localparam int M_IDLE  = 0;
    localparam int M_BUILD = 1;
    localparam int M_SKIP  = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic [WWIDTH-1:0] enter_a;
    logic [WWIDTH-1:0] enter_b;
    logic [TWIDTH-1:0] enter_tag;
    logic              enter_start;
    logic              enter_valid;
    logic              enter_bp;
    logic [BWIDTH-1:0] out_a;
    logic [BWIDTH-1:0] out_b;
    logic [TWIDTH-1:0] out_tag;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       sts_num_queued;
    logic [15:0]       sts_err;

    always #5 clk = ~clk;

    accelbrot_enter_deser #(
        .NWORDS(NWORDS), .WWIDTH(WWIDTH), .PWIDTH(PWIDTH), .DEPTH(DEPTH), .BP_SLACK(BP_SLACK)
    ) dut (
        .clk(clk), .rstn(rstn),
        .enter_a(enter_a), .enter_b(enter_b), .enter_tag(enter_tag),
        .enter_start(enter_start), .enter_valid(enter_valid), .enter_bp(enter_bp),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .sts_num_queued(sts_num_queued), .sts_err(sts_err)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    typedef struct {
        logic [BWIDTH-1:0] a;
        logic [BWIDTH-1:0] b;
        logic [TWIDTH-1:0] tag;
    } BlkT;

    BlkT               mQueue[$];
    int                mMode;
    logic [WWIDTH-1:0] mWordA[NWORDS];
    logic [WWIDTH-1:0] mWordB[NWORDS];
    logic [TWIDTH-1:0] mTag;
    int                mGot;
    int                mLeft;
    int                mErr;
    int                mSts;
    logic              mBp;

    typedef struct {
        int                cycles;
        logic              valid;
        logic              start;
        logic [TWIDTH-1:0] tag;
        logic [WWIDTH-1:0] aBase;
        logic [WWIDTH-1:0] bBase;
        logic              ready;
        logic              rst;
        logic              expBp;
        logic              expValid;
        int                expQueued;
        int                expErr;
        logic              chkT1;
    } SegT;

    SegT segs[$];

    function automatic void addSeg(int cycles, logic valid, logic start, logic [TWIDTH-1:0] tag,
                                   logic [WWIDTH-1:0] aBase, logic [WWIDTH-1:0] bBase, logic ready,
                                   logic rst, logic expBp, logic expValid, int expQueued, int expErr,
                                   logic chkT1);
        SegT s;
        s.cycles = cycles; s.valid = valid; s.start = start; s.tag = tag;
        s.aBase = aBase; s.bBase = bBase; s.ready = ready; s.rst = rst;
        s.expBp = expBp; s.expValid = expValid; s.expQueued = expQueued; s.expErr = expErr;
        s.chkT1 = chkT1;
        segs.push_back(s);
    endfunction

    function automatic int errSeen(int count);
`ifdef ACCELBROT_ENTER_DESER_CHECK_EN
        return count;
`else
        return 0;
`endif
    endfunction

    task automatic checkVal(input string name, input logic [BWIDTH-1:0] act, input logic [BWIDTH-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Block-level reference: committed blocks live in a queue, the block under construction in word arrays.
    task automatic modelStep(input logic v, input logic s, input logic [WWIDTH-1:0] a,
                             input logic [WWIDTH-1:0] b, input logic [TWIDTH-1:0] t,
                             input logic r, input logic rst);
        bit  full, popNow, commitNow;
        BlkT blk;
        if (!rst) begin
            mQueue.delete();
            mMode = M_IDLE; mGot = 0; mLeft = 0; mErr = 0; mSts = 0; mBp = 1'b1;
            return;
        end
        full      = (mQueue.size() == DEPTH);
        popNow    = (mQueue.size() > 0) && r;
        commitNow = 0;
        if (v) begin
            if (s) begin
                if ((mMode != M_IDLE || full) && mErr < 65535) mErr++;
                if (full) begin
                    mMode = (NWORDS == 1) ? M_IDLE : M_SKIP;
                    mLeft = NWORDS - 1;
                end else begin
                    mWordA[0] = a; mWordB[0] = b; mTag = t; mGot = 1;
                    if (NWORDS == 1) begin
                        commitNow = 1; mMode = M_IDLE;
                    end else begin
                        mMode = M_BUILD;
                    end
                end
            end else if (mMode == M_IDLE) begin
                if (mErr < 65535) mErr++;
            end else if (mMode == M_BUILD) begin
                mWordA[mGot] = a; mWordB[mGot] = b; mGot++;
                if (mGot == NWORDS) begin
                    commitNow = 1; mMode = M_IDLE;
                end
            end else begin
                mLeft--;
                if (mLeft == 0) mMode = M_IDLE;
            end
        end
        blk.a = '0; blk.b = '0; blk.tag = mTag;
        for (int k = 0; k < NWORDS; k++) begin
            blk.a[k*WWIDTH +: WWIDTH] = mWordA[k];
            blk.b[k*WWIDTH +: WWIDTH] = mWordB[k];
        end
        mSts = mQueue.size();
        if (popNow) void'(mQueue.pop_front());
        if (commitNow) mQueue.push_back(blk);
        mBp = ((DEPTH - mQueue.size() - ((mMode == M_BUILD) ? 1 : 0)) <= BP_SLACK);
    endtask

    task automatic checkOutput();
        BlkT  head;
        logic expValid;
        expValid = (mQueue.size() > 0);
        if (expValid) head = mQueue[0];
        else begin
            head.a = '0; head.b = '0; head.tag = '0;
        end
        checkVal("out_valid", out_valid, expValid);
        checkVal("out_a", out_a, head.a);
        checkVal("out_b", out_b, head.b);
        checkVal("out_tag", out_tag, head.tag);
        checkVal("enter_bp", enter_bp, mBp);
        checkVal("sts_num_queued", sts_num_queued, mSts);
        checkVal("sts_err", sts_err, errSeen(mErr));
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [WWIDTH-1:0] a,
                                 input logic [WWIDTH-1:0] b, input logic [TWIDTH-1:0] t,
                                 input logic r, input logic rst);
        enter_valid = v; enter_start = s; enter_a = a; enter_b = b; enter_tag = t;
        out_ready = r; rstn = rst;
        @(posedge clk);
        modelStep(v, s, a, b, t, r, rst);
        #1;
        checkOutput();
    endtask

    function automatic logic [WWIDTH-1:0] rndWord();
        return WWIDTH'({$urandom(), $urandom()});
    endfunction

    initial begin
        logic [WWIDTH-1:0] curA, curB, va, vb;
        logic [TWIDTH-1:0] vt;
        logic              vs, vv, vr;
        int                idx;
        bit                inBlock;
        int                wordsLeft;
        int                rr;

        enter_valid = 0; enter_start = 0; enter_a = '0; enter_b = '0; enter_tag = '0;
        out_ready = 0; rstn = 0;
        curA = '0; curB = '0; idx = 0;

        applyStimulus(0, 0, '0, '0, '0, 0, 0);
        applyStimulus(0, 0, '0, '0, '0, 0, 0);
        checkVal("reset_bp", enter_bp, 1'b1);
        checkVal("reset_valid", out_valid, 1'b0);
        checkVal("reset_queued", sts_num_queued, 0);

        //     cyc v s tag        aBase    bBase    rdy rst  bp v  q  err t1
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 0, 0, 0);
        addSeg(7, 1, 1, 24'h00A005, 34'h1,  34'h100, 1, 1,  0, 0, 0, 0, 0);
        addSeg(1, 1, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 1, 0, 0, 1);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 1, 0, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 0, 0, 0);
        addSeg(3, 1, 1, 24'h000111, 34'h1000, 34'h2000, 0, 1, 0, 0, 0, 0, 0);
        addSeg(2, 0, 0, 24'h0,     34'h0,   34'h0,   0, 1,  0, 0, 0, 0, 0);
        addSeg(5, 1, 0, 24'h0,     34'h0,   34'h0,   0, 1,  0, 1, 0, 0, 0);
        addSeg(8, 1, 1, 24'h000222, 34'h3000, 34'h4000, 0, 1, 0, 1, 1, 0, 0);
        addSeg(1, 1, 1, 24'h000333, 34'h5000, 34'h6000, 0, 1, 1, 1, 2, 0, 0);
        addSeg(7, 1, 0, 24'h0,     34'h0,   34'h0,   0, 1,  1, 1, 2, 0, 0);
        addSeg(8, 1, 1, 24'h000444, 34'h7000, 34'h8000, 0, 1, 1, 1, 3, 0, 0);
        addSeg(8, 1, 1, 24'h000555, 34'h9000, 34'hA000, 0, 1, 1, 1, 4, 1, 0);
        addSeg(4, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 1, 1, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 0, 1, 0);
        addSeg(5, 1, 1, 24'h000666, 34'hB000, 34'hC000, 1, 1, 0, 0, 0, 1, 0);
        addSeg(8, 1, 1, 24'h003004, 34'hD000, 34'hE000, 1, 1, 0, 1, 0, 2, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 1, 2, 0);
        addSeg(2, 1, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 0, 4, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 0, 4, 0);
        addSeg(4, 1, 1, 24'h000777, 34'hF000, 34'h11000, 1, 1, 0, 0, 0, 4, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   0, 0,  1, 0, 0, 0, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   0, 1,  0, 0, 0, 0, 0);
        addSeg(8, 1, 1, 24'h000888, 34'h12000, 34'h13000, 0, 1, 0, 1, 0, 0, 0);
        addSeg(1, 0, 0, 24'h0,     34'h0,   34'h0,   1, 1,  0, 0, 1, 0, 0);

        for (int i = 0; i < segs.size(); i++) begin
            for (int c = 0; c < segs[i].cycles; c++) begin
                vv = segs[i].valid;
                vs = segs[i].valid && segs[i].start && (c == 0);
                vt = TWIDTH'($urandom());
                if (vs) begin
                    curA = segs[i].aBase; curB = segs[i].bBase; idx = 0; vt = segs[i].tag;
                end
                if (vv) begin
                    va = curA + WWIDTH'(idx); vb = curB + WWIDTH'(idx); idx++;
                end else begin
                    va = rndWord(); vb = rndWord();
                end
                applyStimulus(vv, vs, va, vb, vt, segs[i].ready, segs[i].rst);
            end
            checkVal($sformatf("seg%0d_bp", i), enter_bp, segs[i].expBp);
            checkVal($sformatf("seg%0d_valid", i), out_valid, segs[i].expValid);
            checkVal($sformatf("seg%0d_queued", i), sts_num_queued, segs[i].expQueued);
            checkVal($sformatf("seg%0d_err", i), sts_err, errSeen(segs[i].expErr));
            if (segs[i].chkT1) begin
                for (int k = 0; k < NWORDS; k++) begin
                    checkVal($sformatf("t1_a%0d", k), out_a[k*WWIDTH +: WWIDTH], WWIDTH'(k + 1));
                    checkVal($sformatf("t1_b%0d", k), out_b[k*WWIDTH +: WWIDTH], WWIDTH'(32'h100 + k));
                end
                checkVal("t1_tag", out_tag, 24'h00A005);
            end
        end

        inBlock = 0; wordsLeft = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc < 500) vr = 1'($urandom_range(0, 1));
            else if (cyc < 1000) vr = 1'(cyc % 2);
            else vr = ((cyc % 40) >= 30);
            vv = 0; vs = 0;
            va = rndWord(); vb = rndWord(); vt = TWIDTH'($urandom());
            rr = $urandom_range(0, 99);
            if (inBlock) begin
                if (rr < 70) begin
                    vv = 1;
                    if ($urandom_range(0, 49) == 0) begin
                        vs = 1; wordsLeft = NWORDS - 1;
                    end else begin
                        wordsLeft--;
                    end
                    if (wordsLeft == 0) inBlock = 0;
                end
            end else if (rr < 50 && (!enter_bp || $urandom_range(0, 9) == 0)) begin
                vv = 1; vs = 1; inBlock = (NWORDS > 1); wordsLeft = NWORDS - 1;
            end else if (rr > 97) begin
                vv = 1;
            end
            applyStimulus(vv, vs, va, vb, vt, vr, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/accelbrot_enter_deser.md
# accelbrot_enter_deser

Receiving end of the word-serial `enter` interface produced by the pixel-coordinate queue. It reassembles NWORDS-beat (a, b) words into full-width blocks with their tag and buffers them in a small block FIFO. It presents the blocks block-parallel with a valid/ready handshake to downstream consumers (e.g. a host-readback or block-mode core). It also generates `enter_bp` so the sender never starts a block that cannot be stored.

## Interface
- NWORDS, 8, words per block
- WWIDTH, 34, bits per word
- PWIDTH, 12, pixel coordinate width
- DEPTH, 4, block FIFO depth (≥2)
- BP_SLACK, 1, blocks the sender may still start after `enter_bp` rises (covers its decision-to-start latency)
- BWIDTH, NWORDS*WWIDTH, block width (derived)
- TWIDTH, PWIDTH*2, tag width (derived)

- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- enter_a  in  WWIDTH  a word
- enter_b  in  WWIDTH  b word
- enter_tag  in  TWIDTH  {y, x}, sampled on start beat only
- enter_start  in  1  first word of block (qualified by enter_valid)
- enter_valid  in  1  word valid
- enter_bp  out  1  backpressure to sender, registered
- out_a  out  BWIDTH  assembled a
- out_b  out  BWIDTH  assembled b
- out_tag  out  TWIDTH  tag
- out_valid  out  1  head block valid
- out_ready  in  1  consumer accepts head block
- sts_num_queued  out  32  committed blocks in FIFO, registered
- sts_err  out  16  saturating protocol/overflow error count

## Operation
- Word order: first beat is word 0 → bits [0 +: WWIDTH]; beat k → [k*WWIDTH +: WWIDTH]; same for a and b.
- FSM:
  - IDLE: beat with start=1 → ASSEMBLE, word cnt=1, tag latched. Beat with start=0 is dropped; counts as an error.
  - ASSEMBLE: each valid beat stores word cnt and increments cnt. Beat cnt=NWORDS-1 commits the block to the FIFO → IDLE. Cycles without valid hold state; gaps are legal.
  - Start during ASSEMBLE: partial block discarded, one error, assembly restarts with this beat as word 0 and new tag.
- Reservation: the start beat reserves one FIFO slot. free = DEPTH − committed − (state==ASSEMBLE).
- Overflow: a start beat with free==0 → block dropped (FSM enters DROP: consume NWORDS−1 further beats, then IDLE), one error. FIFO contents unaffected.
- NWORDS==1: start beat commits directly; ASSEMBLE is never entered.
- Output: first-word-fall-through. out_* reflect the head entry. Pop when out_valid && out_ready. out_* hold stable while out_valid && !out_ready.
- Simultaneous commit and pop: occupancy unchanged; commit to full FIFO with same-cycle pop is impossible because the slot was reserved.
- enter_bp <= (free_next ≤ BP_SLACK), where free_next accounts for this cycle's start, commit and pop.
- sts_err saturates at 16'hFFFF.

## Timing
- Reset values: enter_bp=1, out_valid=0, out_a/out_b/out_tag=0, sts_num_queued=0, sts_err=0. FSM=IDLE, FIFO empty, partial block discarded.
- Reset mid-block: assembly lost. First cycle after rstn=1: enter_bp=1. Second cycle: enter_bp=0 if DEPTH>BP_SLACK.
- Latency: last word beat in cycle N → out_valid=1 in cycle N+1 (when FIFO was empty).
- Pop in cycle N → next entry on out_* in N+1. Throughput one block per cycle at output.
- enter_bp reacts one cycle after the state change that causes it.
- sts_num_queued lags occupancy by one cycle.

## Configuration
- ACCELBROT_ENTER_DESER_CHECK_EN defined: error detection as above, sts_err counts.
- Not defined: sts_err tied 0, no error counter logic. Orphan beats are still dropped; mid-block start still restarts; overflow blocks are still dropped. Datapath behaviour is identical.

## Test plan
- Single block, NWORDS=8, words a=k+1, b=0x100+k, tag=0x00A005, out_ready=1 → out_a word k = k+1, out_b word k = 0x100+k, out_tag=0x00A005, out_valid=1 exactly one cycle after the 8th beat.
- 2-cycle gap after beat 3, out_ready=0, DEPTH=4, BP_SLACK=1, 3 blocks back-to-back → all 3 assembled intact. enter_bp=1 the cycle after the 3rd block's start beat (free=1). 4th block accepted. 5th start is dropped, sts_err=1, sts_num_queued=4.
- Restart on beat 5 with new tag 0x003004 → only the restarted block is committed, with tag 0x003004; sts_err=1.
- Orphan beats (valid, no start) in IDLE → nothing committed, sts_err=2; with the macro undefined, sts_err=0.
- Full FIFO, out_ready toggling 1/0 while blocks stream in → output order preserved, no loss. sts_num_queued tracks occupancy with 1-cycle lag. Simultaneous commit+pop keeps count constant.
- rstn=0 at beat 4, release → enter_bp=1 then 0, out_valid=0; a fresh block then arrives correctly.
